// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the front-end pipeline control slice.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard compare between the ID source fields and the EX destination.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_m2reg,
  input  logic       ex_wreg,
  input  logic [4:0] ex_rn,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs && (id_rs == ex_rn);
  assign rt_hit = id_use_rt && (id_rt == ex_rn);
  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign lu     = ex_m2reg && ex_wreg && (ex_rn != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use stalls, multi-cycle MDU sequencing with timeout, branch flush.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [4:0]    ex_rn,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic          id_is_mdu,
  input  logic          id_branch_taken,
  input  logic          mdu_done,
  output logic          pc_we,
  output logic          ifid_we,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic          mdu_start,
  output logic          mdu_err,
  output logic [CW-1:0] stall_cnt
);

  localparam int BW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [BW-1:0] BUSY_LAST = BW'(MDU_TIMEOUT - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] busy_cnt;
  logic          lu;
  logic          timeout;

  hazard_cmp u_hazard_cmp (
    .ex_m2reg  (ex_m2reg),
    .ex_wreg   (ex_wreg),
    .ex_rn     (ex_rn),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .lu        (lu)
  );

  assign timeout = (state == BUSY) && (busy_cnt == BUSY_LAST) && !mdu_done;

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mdu_start   = 1'b0;
    state_nxt   = state;
    if (clrn) begin
      unique case (state)
        IDLE: begin
          if (lu) begin
            idex_bubble = 1'b1;
          end else if (id_is_mdu) begin
            mdu_start   = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = BUSY;
          end else begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = id_branch_taken;
          end
        end
        BUSY: begin
          // A timeout releases exactly like a completion so the pipeline never wedges.
          if (mdu_done || timeout) begin
            pc_we     = 1'b1;
            ifid_we   = 1'b1;
            state_nxt = IDLE;
          end else begin
            idex_bubble = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      busy_cnt  <= '0;
      mdu_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == BUSY && state_nxt == IDLE) begin
        busy_cnt <= '0;
      end else if (state == BUSY) begin
        busy_cnt <= busy_cnt + 1'b1;
      end
      if (timeout) begin
        mdu_err <= 1'b1;
      end
      if (!pc_we) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  id_rs, id_rt, ex_rn;
  logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg;
  logic        id_is_mdu, id_branch_taken, mdu_done;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, mdu_start, mdu_err;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MDU_TIMEOUT(8), .CW(16)) dut (
    .clk             (clk),
    .clrn            (clrn),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .ex_rn           (ex_rn),
    .ex_wreg         (ex_wreg),
    .ex_m2reg        (ex_m2reg),
    .id_is_mdu       (id_is_mdu),
    .id_branch_taken (id_branch_taken),
    .mdu_done        (mdu_done),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .mdu_start       (mdu_start),
    .mdu_err         (mdu_err),
    .stall_cnt       (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, mdu_start}
  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, mdu_start}, {27'd0, exp});
  endtask

  task automatic quiet();
    id_rs = 5'd0; id_rt = 5'd0; ex_rn = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
    id_is_mdu = 1'b0; id_branch_taken = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    clrn = 1'b0;
    quiet();
    next_cycle(); #1;
    chk_out("reset_outs", 5'b00000);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_mdu_err", {31'd0, mdu_err}, 32'd0);

    clrn = 1'b1; #1;
    chk_out("idle_run", 5'b11000);

    // Load-use on rs
    next_cycle();
    ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rn = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; #1;
    chk_out("lu_rs_stall", 5'b00010);
    next_cycle();
    quiet(); #1;
    chk_out("lu_rs_release", 5'b11000);
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Register 0 and unused source never stall
    next_cycle();
    ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rn = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1; #1;
    chk_out("lu_reg0", 5'b11000);
    next_cycle();
    ex_rn = 5'd8; id_rs = 5'd8; id_use_rs = 1'b0; #1;
    chk_out("lu_no_use", 5'b11000);
    next_cycle();
    id_rt = 5'd8; id_use_rt = 1'b1; #1;
    chk_out("lu_rt_stall", 5'b00010);
    next_cycle();
    quiet(); #1;
    chk("lu_rt_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // Branch during a load-use stall: no flush until the stall clears
    next_cycle();
    ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rn = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
    id_branch_taken = 1'b1; #1;
    chk_out("br_lu_stall", 5'b00010);
    next_cycle();
    quiet(); id_branch_taken = 1'b1; #1;
    chk_out("br_flush", 5'b11100);
    chk("br_stall_cnt", {16'd0, stall_cnt}, 32'd3);

    // mdu_done in IDLE is ignored
    next_cycle();
    quiet(); mdu_done = 1'b1; #1;
    chk_out("idle_done_ignored", 5'b11000);

    // MDU op: start, 5 waiting BUSY cycles, done
    next_cycle();
    quiet(); id_is_mdu = 1'b1; mdu_done = 1'b1; #1;
    chk_out("mdu_start", 5'b00011);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      mdu_done = 1'b0; #1;
      chk_out($sformatf("mdu_wait%0d", i), 5'b00010);
    end
    next_cycle();
    mdu_done = 1'b1; #1;
    chk_out("mdu_done_release", 5'b11000);
    next_cycle();
    quiet(); #1;
    chk_out("mdu_back_idle", 5'b11000);
    chk("mdu_stall_cnt", {16'd0, stall_cnt}, 32'd9);
    chk("mdu_no_err", {31'd0, mdu_err}, 32'd0);

    // MDU timeout: 7 stalled BUSY cycles then forced release on the 8th
    next_cycle();
    id_is_mdu = 1'b1; #1;
    chk_out("to_start", 5'b00011);
    for (int i = 0; i < 7; i++) begin
      next_cycle(); #1;
      chk_out($sformatf("to_wait%0d", i), 5'b00010);
    end
    next_cycle(); #1;
    chk_out("to_release", 5'b11000);
    chk("to_err_before_edge", {31'd0, mdu_err}, 32'd0);
    next_cycle();
    quiet(); #1;
    chk("to_err_set", {31'd0, mdu_err}, 32'd1);
    chk_out("to_back_idle", 5'b11000);
    chk("to_stall_cnt", {16'd0, stall_cnt}, 32'd17);
    next_cycle(); next_cycle(); #1;
    chk("to_err_sticky", {31'd0, mdu_err}, 32'd1);

    // Reset pulsed mid-BUSY
    next_cycle();
    id_is_mdu = 1'b1; #1;
    chk_out("rst_mdu_start", 5'b00011);
    next_cycle(); #1;
    chk_out("rst_mdu_busy", 5'b00010);
    next_cycle();
    clrn = 1'b0; #1;
    chk_out("rst_outs_zero", 5'b00000);
    chk("rst_err_clear", {31'd0, mdu_err}, 32'd0);
    chk("rst_stall_clear", {16'd0, stall_cnt}, 32'd0);
    next_cycle();
    id_is_mdu = 1'b0; clrn = 1'b1; #1;
    chk_out("rst_idle_no_start", 5'b11000);
    next_cycle(); #1;
    chk("rst_stall_after", {16'd0, stall_cnt}, 32'd0);
    id_is_mdu = 1'b1; #1;
    chk_out("rst_new_start", 5'b00011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
